// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU driven directly by the ALU decoder's alu_control.
// ADD/SUB/AND/OR/XOR/SLT/SLTU complete in one cycle. SLL/SRL/SRA run on an
// iterative shifter that moves up to SHIFT_STEP bit positions per cycle.
// Valid/ready handshakes on both sides. A single registered slot holds each
// result until the consumer takes it.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o      operation handshake (alu_control_i, src_a_i, src_b_i)
//   alu_control_i          4-bit operation code
//   src_a_i, src_b_i       operands; src_b_i low bits give the shift amount
//   flush_i                abort the in-flight shift and drop the held result
//   valid_o / ready_i      result handshake (result_o, zero_o)
//   result_o, zero_o       registered result and (result_o == 0)
//   busy_o                 high while the iterative shifter is running
module seq_alu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            alu_control_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  busy_o
);

    localparam int unsigned SW = $clog2(DATA_WIDTH);
    // One extra bit so a step of DATA_WIDTH is representable.
    localparam logic [SW:0] STEP_MAX = (SW + 1)'(SHIFT_STEP);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_XOR  = 4'b1001
    } alu_op_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [SW-1:0]         remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  valid_d;

    logic [SW-1:0]         shamt;
    logic                  is_shift;
    logic                  accept;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [SW:0]           step;
    logic [DATA_WIDTH-1:0] shifted;

    assign shamt    = src_b_i[SW-1:0];
    assign is_shift = (alu_control_i == OP_SLL) || (alu_control_i == OP_SRL) ||
                      (alu_control_i == OP_SRA);
    assign ready_o  = (state_q == IDLE) && (!valid_o || ready_i) && !flush_i;
    assign accept   = valid_i && ready_o;
    assign busy_o   = (state_q == SHIFT);

    // Single-cycle results. Shift codes only reach this path with shamt == 0.
    always_comb begin
        alu_res = '0;
        case (alu_control_i)
            OP_ADD:  alu_res = src_a_i + src_b_i;
            OP_SUB:  alu_res = src_a_i - src_b_i;
            OP_AND:  alu_res = src_a_i & src_b_i;
            OP_OR:   alu_res = src_a_i | src_b_i;
            OP_XOR:  alu_res = src_a_i ^ src_b_i;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (src_a_i < src_b_i)};
            OP_SLL, OP_SRL, OP_SRA: alu_res = src_a_i;
            default: alu_res = '0;
        endcase
    end

    // Iterative shifter step. SRA keeps the MSB of the working register,
    // which is always the original operand's sign bit.
    always_comb begin
        step = ({1'b0, remaining_q} < STEP_MAX) ? {1'b0, remaining_q} : STEP_MAX;
        case (op_q)
            OP_SLL:  shifted = work_q << step;
            OP_SRL:  shifted = work_q >> step;
            default: shifted = DATA_WIDTH'($signed(work_q) >>> step);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        result_d    = result_o;
        valid_d     = valid_o && !ready_i;
        if (flush_i) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            remaining_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            state_d     = SHIFT;
                            op_d        = alu_control_i;
                            work_d      = src_a_i;
                            remaining_d = shamt;
                        end else begin
                            result_d = alu_res;
                            valid_d  = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_d      = shifted;
                    remaining_d = remaining_q - step[SW-1:0];
                    if ({1'b0, remaining_q} == step) begin
                        result_d = shifted;
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            remaining_q <= '0;
            result_o    <= '0;
            zero_o      <= 1'b1;
            valid_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            result_o    <= result_d;
            zero_o      <= (result_d == '0);
            valid_o     <= valid_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: table of vectors run back-to-back through a scoreboard,
// plus hand sequences for output stall, flush, reset mid-shift and SHIFT_STEP=8.
module tb_seq_alu;

    localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0001, C_AND = 4'b0010,
                           C_OR  = 4'b0011, C_SLL = 4'b0100, C_SLT = 4'b0101,
                           C_SRL = 4'b0110, C_SRA = 4'b0111, C_SLTU = 4'b1000,
                           C_XOR = 4'b1001;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  alu_control_i = '0;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;

    logic        valid8 = 1'b0;
    logic        ready8;
    logic [3:0]  ctrl8 = '0;
    logic [31:0] a8 = '0;
    logic [31:0] b8 = '0;
    logic        vout8;
    logic [31:0] res8;
    logic        zero8;
    logic        busy8;

    seq_alu #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .alu_control_i(alu_control_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .zero_o(zero_o), .busy_o(busy_o)
    );

    seq_alu #(.DATA_WIDTH(32), .SHIFT_STEP(8)) u_dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid8), .ready_o(ready8),
        .alu_control_i(ctrl8), .src_a_i(a8), .src_b_i(b8),
        .flush_i(1'b0), .valid_o(vout8), .ready_i(1'b1),
        .result_o(res8), .zero_o(zero8), .busy_o(busy8)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          acc;
        int          lat;
    } sb_t;

    sb_t q[$];
    bit  head_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present an op (valid_i left high) and wait for acceptance. Returns just
    // after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input bit push);
        bit ok = 1'b0;
        alu_control_i = c;
        src_a_i       = a;
        src_b_i       = b;
        valid_i       = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                if (push) q.push_back('{e, cyc, lat});
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: ready_o never rose for op 0x%h", c);
            valid_i = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
    endtask

    // Scoreboard: compare every visible result against the queue head.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_valid: valid_o=1 result=0x%h with no expected result", result_o);
            end else begin
                if (!head_seen) begin
                    check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    head_seen = 1'b1;
                end
                check("result", result_o, q[0].exp);
                check("zero", {31'b0, zero_o}, {31'b0, (q[0].exp == 32'd0)});
                if (ready_i) begin
                    void'(q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[18];
    int   cnt;

    initial begin
        vecs[0]  = '{C_ADD,  32'd5,          32'd7,          32'd12,         1};
        vecs[1]  = '{C_SUB,  32'h3,          32'h3,          32'h0,          1};
        vecs[2]  = '{C_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1};
        vecs[3]  = '{C_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1};
        vecs[4]  = '{C_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1};
        vecs[5]  = '{C_OR,   32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1};
        vecs[6]  = '{C_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  1};
        vecs[7]  = '{C_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1};
        vecs[8]  = '{C_SUB,  32'd0,          32'd1,          32'hFFFF_FFFF,  1};
        vecs[9]  = '{C_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,          1};
        vecs[10] = '{C_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,          1};
        vecs[11] = '{C_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  5};
        vecs[12] = '{C_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000,  5};
        vecs[13] = '{C_SLL,  32'd1,          32'd31,         32'h8000_0000,  32};
        vecs[14] = '{C_SLL,  32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[15] = '{4'b1010, 32'd9,         32'd9,          32'd0,          1};
        vecs[16] = '{C_SRA,  32'h7FFF_FFF0,  32'd4,          32'h07FF_FFFF,  5};
        vecs[17] = '{C_SLL,  32'd3,          32'h0000_0025,  32'h0000_0060,  6};

        // Reset values.
        #12;
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'b0, zero_o}, 32'd1);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Table vectors, back-to-back, consumer always ready.
        foreach (vecs[i])
            send(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
        valid_i = 1'b0;
        drain();

        // Consumer stalls: result held, next op blocked.
        ready_i = 1'b0;
        send(C_ADD, 32'h0000_1230, 32'd4, 32'h0000_1234, 1, 1'b1);
        alu_control_i = C_SUB;
        src_a_i = 32'd10;
        src_b_i = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_ready", {31'b0, ready_o}, 32'd0);
            check("stall_valid", {31'b0, valid_o}, 32'd1);
            check("stall_result", result_o, 32'h0000_1234);
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        send(C_SUB, 32'd10, 32'd3, 32'd7, 1, 1'b1);
        valid_i = 1'b0;
        drain();

        // Flush mid-shift; flush also wins over a new op in IDLE.
        send(C_SLL, 32'd1, 32'd20, 32'd0, 0, 1'b0);
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        alu_control_i = C_ADD;
        src_a_i = 32'd1;
        src_b_i = 32'd1;
        valid_i = 1'b1;
        @(negedge clk_i);
        check("preflush_busy", {31'b0, busy_o}, 32'd1);
        @(negedge clk_i);
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        check("flush_beats_valid", {31'b0, ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("postflush_valid", {31'b0, valid_o}, 32'd0);
        check("postflush_ready", {31'b0, ready_o}, 32'd1);
        check("postflush_result", result_o, 32'd7);
        repeat (30) @(posedge clk_i);
        #1;

        // Reset mid-shift.
        send(C_SLL, 32'd1, 32'd20, 32'd0, 0, 1'b0);
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_valid", {31'b0, valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_zero", {31'b0, zero_o}, 32'd1);
        check("midrst_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // SHIFT_STEP=8: SLL 1<<31 valid at cycle 5.
        ctrl8 = C_SLL;
        a8 = 32'd1;
        b8 = 32'd31;
        valid8 = 1'b1;
        @(negedge clk_i);
        check("step8_ready", {31'b0, ready8}, 32'd1);
        @(posedge clk_i);
        #1;
        valid8 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            cnt++;
            if (vout8) break;
        end
        check("step8_latency", 32'(cnt), 32'd5);
        check("step8_result", res8, 32'h8000_0000);
        check("step8_zero", {31'b0, zero8}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
